// File: rtl/branch_pc_unit.sv
// Program counter with branch/jump redirection, a one-cycle fetch flush,
// halt, stall freeze and a saturating redirect counter.
module branch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] shifted_offset,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        halt,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        flush,
  output logic        halted,
  output logic [15:0] taken_count
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        flush_q, flush_d;
  logic        halted_q, halted_d;
  logic [15:0] taken_count_q, taken_count_d;

  logic [31:0] branch_tgt;
  logic [31:0] jump_tgt;
  logic        taken;
  logic [15:0] count_inc;

  // Sequential successor and redirect targets derived from the current pc.
  always_comb begin
    pc_plus4   = pc_q + 32'd4;
    branch_tgt = pc_plus4 + shifted_offset;
    jump_tgt   = {pc_plus4[31:28], jump_index, 2'b00};
    taken      = branch && zero;
    count_inc  = (taken_count_q == '1) ? taken_count_q : taken_count_q + 16'd1;
  end

  // Next-state logic: stall freezes everything, including flush/halted.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    flush_d       = flush_q;
    halted_d      = halted_q;
    taken_count_d = taken_count_q;
    if (!stall) begin
      unique case (state_q)
        RUN: begin
          if (halt) begin
            state_d  = HALT;
            halted_d = 1'b1;
            flush_d  = 1'b0;
          end else if (jump) begin
            pc_d          = jump_tgt;
            taken_count_d = count_inc;
            state_d       = FLUSH;
            flush_d       = 1'b1;
          end else if (taken) begin
            pc_d          = branch_tgt;
            taken_count_d = count_inc;
            state_d       = FLUSH;
            flush_d       = 1'b1;
          end else begin
            pc_d    = pc_plus4;
            flush_d = 1'b0;
          end
        end
        FLUSH: begin
          pc_d    = pc_plus4;
          state_d = RUN;
          flush_d = 1'b0;
        end
        HALT: begin
          halted_d = 1'b1;
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      flush_q       <= 1'b0;
      halted_q      <= 1'b0;
      taken_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      flush_q       <= flush_d;
      halted_q      <= halted_d;
      taken_count_q <= taken_count_d;
    end
  end

  assign pc          = pc_q;
  assign flush       = flush_q;
  assign halted      = halted_q;
  assign taken_count = taken_count_q;

endmodule

// File: doc/branch_pc_unit.md
BRANCH_PC_UNIT -- requirements
Module: branch_pc_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 stall  input  1  freeze request from the pipeline; holds PC, FSM and counters.
REQ-005 shifted_offset  input  32  sign-extended branch offset already shifted left by 2, taken straight from the shift-left-2 stage output.
REQ-006 branch  input  1  current instruction is a conditional branch (beq).
REQ-007 zero  input  1  ALU zero flag for the current branch.
REQ-008 jump  input  1  current instruction is j.
REQ-009 jump_index  input  26  instruction bits [25:0] for j.
REQ-010 halt  input  1  request to stop fetching.
REQ-011 pc  output  32  current program counter (registered).
REQ-012 pc_plus4  output  32  pc + 4 (combinational, mod 2^32).
REQ-013 flush  output  1  registered; kill the wrong-path instruction in fetch.
REQ-014 halted  output  1  registered; high while in HALT state.
REQ-015 taken_count  output  16  registered count of redirections (taken branches plus jumps).

Function
REQ-016 Branch target SHALL be pc_plus4 + shifted_offset, 32-bit, carry discarded (wrap-around, no error).
REQ-017 Jump target SHALL be {pc_plus4[31:28], jump_index, 2'b00}.
REQ-018 Branch taken SHALL be branch && zero.
REQ-019 FSM states SHALL be RUN, FLUSH, HALT; RUN is the reset state.
REQ-020 Priority in RUN when stall=0: halt > jump > branch taken > sequential.
REQ-021 RUN, stall=0, halt=1: pc holds, next state HALT.
REQ-022 RUN, stall=0, jump=1 (halt=0): pc <= jump target, taken_count increments, next state FLUSH.
REQ-023 RUN, stall=0, branch taken (halt=0, jump=0): pc <= branch target, taken_count increments, next state FLUSH.
REQ-024 RUN, stall=0, no redirect: pc <= pc_plus4, state stays RUN.
REQ-025 FLUSH: flush=1 for exactly that one cycle; branch, jump and halt are ignored; pc <= pc_plus4; next state RUN.
REQ-026 HALT: pc frozen; halted=1; all inputs ignored; only reset exits.
REQ-027 stall=1 in any state: pc, state and taken_count hold; flush and halted hold their current values (a FLUSH cycle is extended until stall drops).
REQ-028 Redirect latency SHALL be one cycle: the target appears on pc on the edge that samples the redirect; flush is high during the following cycle.
REQ-029 taken_count SHALL saturate at 16'hFFFF; no wrap to zero.
REQ-030 jump and branch both high in RUN: jump wins and counts once.
REQ-031 pc SHALL wrap from 32'hFFFFFFFC to 32'h00000000 on sequential advance without any flag.

Reset
REQ-032 reset=1 SHALL immediately (asynchronously) set pc=RESET_PC, state=RUN, flush=0, halted=0, taken_count=0.
REQ-033 Reset asserted mid-FLUSH or in HALT SHALL abandon that state; the first edge after release advances from RESET_PC.
REQ-034 Inputs SHALL be ignored while reset is high.

Verification
REQ-035 Reset, then 3 idle cycles -> pc 0x0, 0x4, 0x8, 0xC; flush=0; taken_count=0.
REQ-036 pc=0x100, branch=1, zero=1, shifted_offset=0x10 -> pc=0x114 next edge, flush=1 one cycle, then pc=0x118, taken_count=1; with zero=0 -> pc=0x104, no flush.
REQ-037 pc=0x100, shifted_offset=0xFFFFFFF0 (-16), branch taken -> pc=0xF4; pc=0xFFFFFFF8 with shifted_offset=0x8 -> pc=0x4 (wrap).
REQ-038 pc=0x40000010, jump=1, branch=1, zero=1, jump_index=0x0000040 -> pc=0x40000100, taken_count +1 only; redirect requests during the FLUSH cycle are ignored.
REQ-039 stall held 3 cycles during FLUSH -> pc and flush=1 held for 3 cycles, then one flush cycle and normal advance; halt=1 -> halted=1, pc frozen for 10 cycles, async reset mid-cycle -> pc=RESET_PC before the next edge.
REQ-040 taken_count preloaded to 0xFFFE by 2 taken branches after forcing -> reaches 0xFFFF and stays 0xFFFF on further jumps.
